// File: rtl/adc_seq_pkg.sv
// Shared constants and state encoding for the ADC128S022-style sequencer.
package adc_seq_pkg;

    localparam int NUM_CH         = 8;
    localparam int DATA_W         = 12;
    localparam int CH_W           = 3;
    localparam int FRAME_LEN      = 16;
    localparam int ADDR_FIRST_BIT = 2;
    localparam int LEAD_BITS      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/adc_seq_ctrl_if.sv
// ADC pin and sample-stream bundle; master is the sequencer, slave is its environment.
interface adc_seq_ctrl_if;
    import adc_seq_pkg::*;

    logic              run;
    logic [NUM_CH-1:0] ch_mask;
    logic              dout;
    logic              adc_cs_n;
    logic              din;
    logic [DATA_W-1:0] data_out;
    logic [CH_W-1:0]   ch_out;
    logic              data_valid;
    logic              busy;
    logic              frame_err;

    modport master (
        input  run, ch_mask, dout,
        output adc_cs_n, din, data_out, ch_out, data_valid, busy, frame_err
    );

    modport slave (
        output run, ch_mask, dout,
        input  adc_cs_n, din, data_out, ch_out, data_valid, busy, frame_err
    );

endinterface

// File: rtl/rr_next_ch.sv
// Round-robin picker: next set mask bit strictly after cur, wrapping; cur=7 yields the lowest set bit.
module rr_next_ch
    import adc_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   next,
    output logic              any
);

    logic [CH_W-1:0] idx_s;
    logic            found_s;

    // Scan forward from cur+1; the final step lands back on cur itself
    always_comb begin
        next    = cur;
        found_s = 1'b0;
        idx_s   = cur;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_s = cur + CH_W'(i);
            if (!found_s && mask[idx_s]) begin
                next    = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/adc_seq_ctrl.sv
// Frame sequencer for an 8-channel 12-bit serial ADC, round-robin over ch_mask.
// Optional leading-zero check on frame bits 0-3 is enabled by defining ADC_LEAD_CHECK_EN.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic          adc_sck,
    input  logic          reset,
    adc_seq_ctrl_if.master bus
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t            state_r, state_next;
    logic [3:0]        bit_cnt_r, bit_cnt_next;
    logic [7:0]        gap_cnt_r, gap_cnt_next;
    logic [CH_W-1:0]   cur_ch_r, cur_ch_next;
    logic [CH_W-1:0]   prev_ch_r, prev_ch_next;
    logic              prev_valid_r, prev_valid_next;
    logic              cs_n_r, cs_n_next;
    logic              din_r, din_next;
    logic [DATA_W-2:0] sh_r, sh_next;
    logic [DATA_W-1:0] data_r, data_next;
    logic [CH_W-1:0]   ch_out_r, ch_out_next;
    logic              dv_r, dv_next;
    logic              busy_r, busy_next;

    logic [CH_W-1:0]   pick_cur_s, pick_ch_s;
    logic              pick_any_s;
    logic [3:0]        nb_s, addr_off_s;

    // From IDLE the picker starts at 7 so it returns the lowest enabled channel
    assign pick_cur_s = (state_r == IDLE) ? 3'd7 : cur_ch_r;
    assign nb_s       = bit_cnt_r + 4'd1;
    assign addr_off_s = nb_s - 4'(ADDR_FIRST_BIT);

    rr_next_ch u_rr (
        .mask (bus.ch_mask),
        .cur  (pick_cur_s),
        .next (pick_ch_s),
        .any  (pick_any_s)
    );

    // Next-state and next-output logic; din is precomputed for the upcoming bit
    always_comb begin
        state_next      = state_r;
        bit_cnt_next    = bit_cnt_r;
        gap_cnt_next    = gap_cnt_r;
        cur_ch_next     = cur_ch_r;
        prev_ch_next    = prev_ch_r;
        prev_valid_next = prev_valid_r;
        cs_n_next       = 1'b1;
        din_next        = 1'b0;
        sh_next         = sh_r;
        data_next       = data_r;
        ch_out_next     = ch_out_r;
        dv_next         = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.run && pick_any_s) begin
                    state_next   = FRAME;
                    bit_cnt_next = 4'd0;
                    cur_ch_next  = pick_ch_s;
                    cs_n_next    = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            FRAME: begin
                sh_next = {sh_r[DATA_W-3:0], bus.dout};
                if (bit_cnt_r == LAST_BIT) begin
                    state_next   = GAP;
                    gap_cnt_next = 8'd0;
                    dv_next      = prev_valid_r;
                    if (prev_valid_r) begin
                        data_next   = {sh_r, bus.dout};
                        ch_out_next = prev_ch_r;
                    end else begin
                        data_next = data_r;
                    end
                end else begin
                    bit_cnt_next = nb_s;
                    cs_n_next    = 1'b0;
                    if (nb_s >= 4'(ADDR_FIRST_BIT) && addr_off_s < 4'(CH_W)) begin
                        din_next = cur_ch_r[2'(CH_W - 1) - addr_off_s[1:0]];
                    end else begin
                        din_next = 1'b0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    prev_ch_next    = cur_ch_r;
                    prev_valid_next = 1'b1;
                    if (bus.run && pick_any_s) begin
                        state_next   = FRAME;
                        bit_cnt_next = 4'd0;
                        cur_ch_next  = pick_ch_s;
                        cs_n_next    = 1'b0;
                    end else begin
                        // The sample still owed for cur_ch is dropped here
                        state_next      = IDLE;
                        prev_valid_next = 1'b0;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_r + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and registered output update
    always_ff @(posedge adc_sck or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 4'd0;
            gap_cnt_r    <= 8'd0;
            cur_ch_r     <= 3'd0;
            prev_ch_r    <= 3'd0;
            prev_valid_r <= 1'b0;
            cs_n_r       <= 1'b1;
            din_r        <= 1'b0;
            sh_r         <= '0;
            data_r       <= '0;
            ch_out_r     <= 3'd0;
            dv_r         <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next;
            bit_cnt_r    <= bit_cnt_next;
            gap_cnt_r    <= gap_cnt_next;
            cur_ch_r     <= cur_ch_next;
            prev_ch_r    <= prev_ch_next;
            prev_valid_r <= prev_valid_next;
            cs_n_r       <= cs_n_next;
            din_r        <= din_next;
            sh_r         <= sh_next;
            data_r       <= data_next;
            ch_out_r     <= ch_out_next;
            dv_r         <= dv_next;
            busy_r       <= busy_next;
        end
    end

`ifdef ADC_LEAD_CHECK_EN
    logic lead_err_r;
    logic frame_err_r;

    // Accumulate any 1 in the leading bits; report it in the frame's strobe slot
    always_ff @(posedge adc_sck or posedge reset) begin
        if (reset) begin
            lead_err_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (state_r == FRAME) begin
                if (bit_cnt_r == 4'd0) begin
                    lead_err_r <= bus.dout;
                end else if (bit_cnt_r < 4'(LEAD_BITS)) begin
                    lead_err_r <= lead_err_r | bus.dout;
                end else begin
                    lead_err_r <= lead_err_r;
                end
                if (bit_cnt_r == LAST_BIT) begin
                    frame_err_r <= lead_err_r;
                end else begin
                    frame_err_r <= 1'b0;
                end
            end else begin
                lead_err_r <= lead_err_r;
            end
        end
    end

    assign bus.frame_err = frame_err_r;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.adc_cs_n   = cs_n_r;
    assign bus.din        = din_r;
    assign bus.data_out   = data_r;
    assign bus.ch_out     = ch_out_r;
    assign bus.data_valid = dv_r;
    assign bus.busy       = busy_r;

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
Sequencer for the 8-channel, 12-bit serial line-sensor ADC (ADC128S022-style, 16-clock frames). It drives chip-select and the channel address bits, captures the serial result, and round-robins over a programmable channel mask. Each completed frame is presented as one 12-bit sample tagged with its channel. It sits between the ADC pins and the line-follower logic, in the adc_sck domain.

Parameters:
NUM_CH, 8, number of ADC channels; channel index width is 3.
DATA_W, 12, result width.
GAP_CYCLES, 1, cycles cs_n is held high between frames; minimum 1.

Ports:
adc_sck  in  1  controller clock; all logic on posedge.
reset  in  1  asynchronous, active-high.
run  in  1  level; 1 = keep converting.
ch_mask  in  NUM_CH  enabled channels; bit i = channel i.
dout  in  1  ADC serial data out, captured on posedge.
adc_cs_n  out  1  ADC chip select, active low.
din  out  1  ADC serial address in.
data_out  out  DATA_W  last completed sample.
ch_out  out  3  channel of data_out.
data_valid  out  1  one-cycle strobe; data_out and ch_out are new.
busy  out  1  high while not IDLE.
frame_err  out  1  leading-zero check failure strobe (see Optional Feature).

Behaviour:
- Reset: adc_cs_n=1, din=0, data_out=0, ch_out=0, data_valid=0, busy=0, frame_err=0, state=IDLE, cur_ch=0, prev_valid=0.
- States: IDLE -> FRAME -> GAP -> FRAME | IDLE.
- IDLE: when run=1 and ch_mask!=0, pick the lowest set mask bit as cur_ch; the next cycle has adc_cs_n=0 and bit_cnt=0 (FRAME).
- FRAME: bit_cnt runs 0..15 with adc_cs_n=0.
  - din = cur_ch[2], cur_ch[1], cur_ch[0] at bit_cnt 2, 3, 4; din=0 at every other bit_cnt.
  - dout captured at bit_cnt k is frame bit k. Bits 0-3 are leading zeros. Bits 4-15 are the result, MSB first.
- End of frame (bit_cnt=15): go to GAP with adc_cs_n=1.
  - On the first GAP cycle, if prev_valid=1: data_valid=1, data_out = shifted result, ch_out = prev_ch.
  - The ADC returns the channel addressed in the previous frame. The first frame after IDLE is therefore a dummy: no data_valid.
- GAP: hold adc_cs_n=1 for GAP_CYCLES cycles. On the last GAP cycle:
  - Set prev_ch=cur_ch and prev_valid=1.
  - If run=1 and ch_mask!=0: cur_ch = next set mask bit strictly after cur_ch, wrapping 7->0. If only cur_ch is set, keep it. Go to FRAME.
  - Otherwise go to IDLE and clear prev_valid. The pending sample of the last addressed channel is discarded.
- Mask changes take effect only at channel selection, i.e. the last GAP cycle or IDLE exit. A frame in flight is never altered.
- run deasserted mid-frame: the frame completes, its result (if prev_valid) is delivered, then IDLE.
- ch_mask=0 with run=1: stay in IDLE, busy=0.
- Reset mid-frame: immediately adc_cs_n=1 and all reset values. The next start begins with a dummy frame.
- Throughput: one sample per 16+GAP_CYCLES cycles in steady state.
- data_out and ch_out hold their values between strobes.

Optional Feature:
Macro ADC_LEAD_CHECK_EN.
- Defined: any 1 captured in frame bits 0-3 raises frame_err for one cycle, coincident with the data_valid slot of that frame (even for a dummy frame). The sample is still delivered.
- Undefined: frame_err is tied to 0 and the check logic is absent.

Decomposition:
- Package adc_seq_pkg:
  - state enum {IDLE, FRAME, GAP}.
  - FRAME_LEN=16.
  - ADDR_FIRST_BIT=2.
  - LEAD_BITS=4.
  - CH_W=3.
- Sub-module rr_next_ch: combinational round-robin picker with inputs mask and cur and outputs next and any. It is reused for the IDLE pick with cur=7, which yields the lowest set bit.

Test Plan:
- Reset: hold reset with run=1 -> adc_cs_n=1, din=0, data_valid=0, busy=0. Assert reset mid-frame at bit_cnt=7 -> adc_cs_n=1 in the same cycle.
- Single channel: ch_mask=8'h04, run=1, ADC model returns 0x0A5C -> din shows 0,1,0 at bit_cnt 2-4. First frame gives no strobe. Every later frame gives data_valid with data_out=12'hA5C, ch_out=2, a period of 17 cycles.
- Round-robin: ch_mask=8'b1001_0010 -> addressed sequence 1,4,7,1,4. Strobed ch_out sequence 1,4,7,1, with each data_out equal to that channel's model value.
- Mask change: switch 8'h01 to 8'h80 mid-frame -> the current frame still addresses 0 and the next addresses 7. Then run=0 at bit_cnt 8 -> the frame completes, one strobe for ch 0, then IDLE and busy=0.
- Empty mask: run=1, ch_mask=0 -> adc_cs_n stays 1 for 100 cycles. Setting ch_mask=8'h08 -> adc_cs_n falls on the next cycle.
- With ADC_LEAD_CHECK_EN: the model drives 1 in frame bit 1 -> frame_err=1 coincident with that frame's strobe slot. Without the macro, frame_err stays 0.
